// File: rtl/uart_pkg.sv
// Shared UART-side constants: host command/op codes, response framing and
// the result TX controller state encoding.
package uart_pkg;

    localparam logic [7:0] CMD_DATOA  = 8'h08;
    localparam logic [7:0] CMD_DATOB  = 8'h10;
    localparam logic [7:0] CMD_OP     = 8'h20;

    localparam logic [7:0] OP_ADD     = 8'h20;
    localparam logic [7:0] OP_SUB     = 8'h22;

    localparam logic [7:0] HDR_RESULT = 8'h30;
    localparam int         FRAME_LEN  = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;

endpackage

// File: rtl/tx_watchdog.sv
// Cycle counter guarding the wait for the TX core's done pulse.
// Expires while the count sits at TOUT_CYCLES-1; TOUT_CYCLES=0 never expires.
module tx_watchdog #(
    parameter int unsigned NB_TOUT     = 20,
    parameter int unsigned TOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam bit                 ENABLED = (TOUT_CYCLES != 0);
    localparam logic [NB_TOUT-1:0] LAST    = NB_TOUT'(TOUT_CYCLES - 1);

    logic [NB_TOUT-1:0] count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= '0;
        end else if (i_en && ENABLED) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = ENABLED && (count == LAST);

endmodule

// File: rtl/uart_result_tx_ctrl.sv
// Turns each ALU result into a {HDR, result, HDR^result} frame for the shared
// UART transmitter, with a one-entry pending buffer and a done watchdog.
module uart_result_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned        NB_DATA     = 8,
    parameter logic [NB_DATA-1:0] HDR_RESULT  = uart_pkg::HDR_RESULT,
    parameter int unsigned        NB_TOUT     = 20,
    parameter int unsigned        TOUT_CYCLES = 200000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_result_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_clr_overrun,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    logic [1:0]         state, state_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [NB_DATA-1:0] frame_res, frame_nxt;
    logic [NB_DATA-1:0] pend_data, pend_data_nxt;
    logic               pend_valid, pend_valid_nxt;
    logic [NB_DATA-1:0] byte_sel, data_nxt;
    logic               start_nxt, tout_nxt, busy_nxt, ovr_nxt, ovr_set;
    logic               wd_load, wd_en, wd_expired;

    always_comb begin
        case (idx)
            2'd0:    byte_sel = HDR_RESULT;
            2'd1:    byte_sel = frame_res;
            default: byte_sel = HDR_RESULT ^ frame_res;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        frame_nxt      = frame_res;
        pend_valid_nxt = pend_valid;
        pend_data_nxt  = pend_data;
        data_nxt       = o_tx_data;
        start_nxt      = 1'b0;
        tout_nxt       = 1'b0;
        ovr_set        = 1'b0;
        wd_load        = 1'b0;
        wd_en          = 1'b0;

        case (state)
            ST_IDLE: begin
                // The older pending entry always wins; a same-cycle result
                // simply refills the slot it just vacated.
                if (pend_valid) begin
                    frame_nxt      = pend_data;
                    pend_valid_nxt = i_result_valid;
                    if (i_result_valid) begin
                        pend_data_nxt = i_result;
                    end
                    state_nxt = ST_START;
                    idx_nxt   = '0;
                end else if (i_result_valid) begin
                    frame_nxt = i_result;
                    state_nxt = ST_START;
                    idx_nxt   = '0;
                end
            end
            ST_START: begin
                start_nxt = 1'b1;
                data_nxt  = byte_sel;
                wd_load   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = ST_START;
                        idx_nxt   = idx + 1'b1;
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_expired) begin
                        tout_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase

        if ((state != ST_IDLE) && i_result_valid) begin
            ovr_set        = pend_valid;
            pend_valid_nxt = 1'b1;
            pend_data_nxt  = i_result;
        end

        ovr_nxt  = ovr_set | (o_overrun & ~i_clr_overrun);
        busy_nxt = (state_nxt != ST_IDLE) | pend_valid_nxt;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_res  <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            frame_res  <= frame_nxt;
            pend_valid <= pend_valid_nxt;
            pend_data  <= pend_data_nxt;
            o_tx_start <= start_nxt;
            o_tx_data  <= data_nxt;
            o_busy     <= busy_nxt;
            o_overrun  <= ovr_nxt;
            o_timeout  <= tout_nxt;
        end
    end

    tx_watchdog #(
        .NB_TOUT     (NB_TOUT),
        .TOUT_CYCLES (TOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_load    (wd_load),
        .i_en      (wd_en),
        .o_expired (wd_expired)
    );

endmodule
